huffman_dc_encoder: RTL

Encodes quantized JPEG DC coefficients into Huffman bit fields: it subtracts the per-component predictor (DPCM), derives the magnitude category, looks up the DC code and appends the magnitude bits. It sits between the quantizer and the bitstream packer. It is the transmit-side counterpart of the DC code/length lookup in the decoder path. It is a 2-stage pipeline with valid/ready on both sides.

---
 rtl/jpeg_huff_pkg.sv | 41 ++++
 rtl/huffman_dc_code_rom.sv | 26 ++
 rtl/huffman_dc_encoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/jpeg_huff_pkg.sv
// rtl/jpeg_huff_pkg.sv - JPEG DC Huffman tables, field type and category helper
package jpeg_huff_pkg;

    localparam int DC_FIELD_W = 22;
    localparam int DC_LEN_W   = 5;
    localparam int DC_CODE_W  = 11;
    localparam int DC_MAX_CAT = 11;

    // Codes are right-aligned; the matching length says how many low bits are sent.
    localparam logic [DC_CODE_W-1:0] LUMA_DC_CODE [12] = '{
        11'd0, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6,
        11'd14, 11'd30, 11'd62, 11'd126, 11'd254, 11'd510
    };
    localparam logic [3:0] LUMA_DC_LEN [12] = '{
        4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9
    };

    localparam logic [DC_CODE_W-1:0] CHROMA_DC_CODE [12] = '{
        11'd0, 11'd1, 11'd2, 11'd6, 11'd14, 11'd30,
        11'd62, 11'd126, 11'd254, 11'd510, 11'd1022, 11'd2046
    };
    localparam logic [3:0] CHROMA_DC_LEN [12] = '{
        4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11
    };

    typedef struct packed {
        logic [DC_FIELD_W-1:0] bits;
        logic [DC_LEN_W-1:0]   len;
    } dc_field_t;

    // Bit length of an unsigned magnitude; 0 maps to category 0.
    function automatic logic [3:0] dc_category(input logic [11:0] mag_abs);
        logic [3:0] cat;
        cat = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (mag_abs[i]) cat = 4'(i + 1);
        end
        return cat;
    endfunction

endpackage

// File: rtl/huffman_dc_code_rom.sv
// rtl/huffman_dc_code_rom.sv - combinational DC code/length lookup by category
// chroma_i selects the chrominance table instead of luminance.
module huffman_dc_code_rom
    import jpeg_huff_pkg::*;
(
    input  logic [3:0]           cat_i,
    input  logic                 chroma_i,
    output logic [DC_CODE_W-1:0] code_o,
    output logic [3:0]           code_len_o
);

    always_comb begin
        code_o     = '0;
        code_len_o = '0;
        if (cat_i <= 4'(DC_MAX_CAT)) begin
            if (chroma_i) begin
                code_o     = CHROMA_DC_CODE[cat_i];
                code_len_o = CHROMA_DC_LEN[cat_i];
            end else begin
                code_o     = LUMA_DC_CODE[cat_i];
                code_len_o = LUMA_DC_LEN[cat_i];
            end
        end
    end

endmodule

// File: rtl/huffman_dc_encoder.sv
// rtl/huffman_dc_encoder.sv - 2-stage JPEG DC DPCM + Huffman field encoder
// Optional HUFF_DC_CHROMA_EN: components >= 1 use the chrominance DC table.
module huffman_dc_encoder
    import jpeg_huff_pkg::*;
#(
    parameter int NUM_COMP = 3,
    parameter int COEF_W   = 11
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic signed [COEF_W-1:0] coef_in,
    input  logic [1:0]              comp_in,
    input  logic                    restart_in,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [DC_FIELD_W-1:0]   bits_out,
    output logic [DC_LEN_W-1:0]     len_out
);

`ifdef HUFF_DC_CHROMA_EN
    localparam bit CHROMA_EN = 1'b1;
`else
    localparam bit CHROMA_EN = 1'b0;
`endif

    localparam int PRED_W = 11;
    localparam int DIFF_W = 12;

    logic [PRED_W-1:0] pred_q [NUM_COMP];
    logic              s1_valid_q;
    logic [DIFF_W-1:0] s1_diff_q;
    logic [3:0]        s1_cat_q;
    logic [1:0]        s1_comp_q;
    logic              s2_valid_q;
    dc_field_t         s2_field_q;

    logic              s1_adv;
    logic              accept;
    logic signed [31:0] coef_ext;
    logic [PRED_W-1:0] coef_clamp;
    logic [PRED_W-1:0] pred_sel;
    logic [DIFF_W-1:0] diff_d;
    logic [DIFF_W-1:0] diff_abs;
    logic [3:0]        cat_d;

    assign s1_adv    = !s2_valid_q || ready_in;
    assign ready_out = s1_adv || !s1_valid_q;
    assign accept    = valid_in && ready_out;

    assign coef_ext = 32'(coef_in);

    always_comb begin
        if (coef_ext > 32'sd1023)       coef_clamp = 11'h3FF;
        else if (coef_ext < -32'sd1024) coef_clamp = 11'h400;
        else                            coef_clamp = coef_ext[PRED_W-1:0];
    end

    // A same-cycle restart wins, and out-of-range components always see predictor 0.
    always_comb begin
        pred_sel = '0;
        if (!restart_in) begin
            for (int i = 0; i < NUM_COMP; i++) begin
                if (comp_in == 2'(i)) pred_sel = pred_q[i];
            end
        end
    end

    assign diff_d   = {coef_clamp[PRED_W-1], coef_clamp} - {pred_sel[PRED_W-1], pred_sel};
    assign diff_abs = diff_d[DIFF_W-1] ? (~diff_d + 12'd1) : diff_d;
    assign cat_d    = dc_category(diff_abs);

    logic [DC_CODE_W-1:0]  code;
    logic [3:0]            code_len;
    logic [DIFF_W-1:0]     diff_adj;
    logic [DIFF_W-1:0]     mag_mask;
    logic [DC_FIELD_W-1:0] mag_ext;
    logic [DC_FIELD_W-1:0] code_sh;
    dc_field_t             field_d;

    huffman_dc_code_rom u_code_rom (
        .cat_i      (s1_cat_q),
        .chroma_i   (CHROMA_EN && (s1_comp_q != 2'd0)),
        .code_o     (code),
        .code_len_o (code_len)
    );

    // Negative differences send the low cat bits of diff-1 (one's complement form).
    assign diff_adj = s1_diff_q[DIFF_W-1] ? (s1_diff_q - 12'd1) : s1_diff_q;
    assign mag_mask = (12'd1 << s1_cat_q) - 12'd1;
    assign mag_ext  = {10'd0, diff_adj & mag_mask};
    assign code_sh  = {11'd0, code} << s1_cat_q;

    always_comb begin
        field_d      = '0;
        field_d.bits = code_sh | mag_ext;
        field_d.len  = {1'b0, code_len} + {1'b0, s1_cat_q};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_COMP; i++) pred_q[i] <= '0;
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_cat_q   <= '0;
            s1_comp_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_field_q <= '0;
        end else begin
            for (int i = 0; i < NUM_COMP; i++) begin
                if (accept && comp_in == 2'(i)) pred_q[i] <= coef_clamp;
                else if (restart_in)            pred_q[i] <= '0;
            end
            if (s1_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_field_q <= field_d;
            end
            if (ready_out) begin
                s1_valid_q <= valid_in;
                if (valid_in) begin
                    s1_diff_q <= diff_d;
                    s1_cat_q  <= cat_d;
                    s1_comp_q <= comp_in;
                end
            end
        end
    end

    assign valid_out = s2_valid_q;
    assign bits_out  = s2_field_q.bits;
    assign len_out   = s2_field_q.len;

endmodule
